// File: rtl/ame_pkg.sv
// Shared widths, matrix type, model mode and controller states for the
// affine motion-estimation normal-matrix accumulator.
package ame_pkg;

  localparam int AME_DATA_W = 64;
  localparam int AME_GRAD_W = 16;
  localparam int AME_POS_W  = 7;
  localparam int AME_NCOEF  = 6;

  // [i][j<6] = A_ij, [i][6] = B_i
  typedef logic [AME_NCOEF-1:0][AME_NCOEF:0][AME_DATA_W-1:0] ame_matrix_t;

  typedef enum logic {
    AFFINE_4P = 1'b0,
    AFFINE_6P = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/ame_coef_gen.sv
// Stage 1: registers the six affine coefficients and the residual of an accepted sample.
// One cycle latency, no backpressure (the caller only presents accepted samples).
module ame_coef_gen
  import ame_pkg::*;
#(
  parameter  int GRAD_BITS = AME_GRAD_W,
  parameter  int POS_BITS  = AME_POS_W,
  localparam int CW        = GRAD_BITS + POS_BITS + 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_vld,
  input  mode_e                       i_mode,
  input  logic signed [GRAD_BITS-1:0] i_gx,
  input  logic signed [GRAD_BITS-1:0] i_gy,
  input  logic        [POS_BITS-1:0]  i_x,
  input  logic        [POS_BITS-1:0]  i_y,
  input  logic signed [GRAD_BITS-1:0] i_diff,
  output logic                        o_vld,
  output logic signed [CW-1:0]        o_coef [AME_NCOEF],
  output logic signed [GRAD_BITS-1:0] o_diff
);

  logic signed [CW-1:0] w_gx, w_gy, w_x, w_y;
  logic signed [CW-1:0] w_xgx, w_xgy, w_ygx, w_ygy;
  logic signed [CW-1:0] w_coef [AME_NCOEF];

  logic                        r_vld;
  logic signed [CW-1:0]        r_coef [AME_NCOEF];
  logic signed [GRAD_BITS-1:0] r_diff;

  // Coordinates are unsigned, so they enter the signed products zero-extended.
  assign w_gx = CW'(i_gx);
  assign w_gy = CW'(i_gy);
  assign w_x  = CW'({1'b0, i_x});
  assign w_y  = CW'({1'b0, i_y});

  assign w_xgx = w_x * w_gx;
  assign w_xgy = w_x * w_gy;
  assign w_ygx = w_y * w_gx;
  assign w_ygy = w_y * w_gy;

  always_comb begin
    w_coef = '{default: '0};
    if (i_mode == AFFINE_6P) begin
      w_coef[0] = w_gx;
      w_coef[1] = w_xgx;
      w_coef[2] = w_gy;
      w_coef[3] = w_xgy;
      w_coef[4] = w_ygx;
      w_coef[5] = w_ygy;
    end else begin
      // Zoom/rotation form: translation in 2,3, scale in 4, rotation in 5.
      w_coef[2] = w_gx;
      w_coef[3] = w_gy;
      w_coef[4] = w_xgx + w_ygy;
      w_coef[5] = w_ygx - w_xgy;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= 1'b0;
      r_coef <= '{default: '0};
      r_diff <= '0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_coef <= w_coef;
        r_diff <= i_diff;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_coef = r_coef;
  assign o_diff = r_diff;

endmodule

// File: rtl/ame_matrix_accumulate.sv
// Accumulates the symmetric 6x6 normal matrix A and vector B of one block; done 3 edges after the last sample.
// Samples are accepted only in ACCUM (ready low otherwise); the result holds until the next block starts.
module ame_matrix_accumulate
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = AME_DATA_W,
  parameter int GRAD_BITS      = AME_GRAD_W,
  parameter int POS_BITS       = AME_POS_W
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        comp_init_i,
  input  logic                        affine_param6_i,
  input  logic                        samp_valid_i,
  output logic                        samp_ready_o,
  input  logic                        samp_last_i,
  input  logic signed [GRAD_BITS-1:0] samp_gx_i,
  input  logic signed [GRAD_BITS-1:0] samp_gy_i,
  input  logic        [POS_BITS-1:0]  samp_x_i,
  input  logic        [POS_BITS-1:0]  samp_y_i,
  input  logic signed [GRAD_BITS-1:0] samp_diff_i,
  output logic                        comp_done_o,
  output logic [AME_NCOEF-1:0][AME_NCOEF:0][COMP_DATA_BITS-1:0] comp_data_o
);

  localparam int CW = GRAD_BITS + POS_BITS + 2;
  localparam int PW = 2 * CW;

  state_t r_state;
  mode_e  r_mode;
  logic   r_ready;
  logic   r_done;
  logic   r_v2;

  logic                        w_take;
  logic                        w_clr;
  logic                        w_v1;
  logic signed [CW-1:0]        w_coef [AME_NCOEF];
  logic signed [GRAD_BITS-1:0] w_diff;

  assign w_take = samp_valid_i & r_ready;
  assign w_clr  = (r_state == IDLE) & comp_init_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_mode  <= AFFINE_4P;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_v2   <= w_v1;
      case (r_state)
        IDLE: begin
          if (comp_init_i) begin
            r_state <= ACCUM;
            r_mode  <= mode_e'(affine_param6_i);
            r_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_take && samp_last_i) begin
            r_state <= FLUSH;
            r_ready <= 1'b0;
          end
        end
        FLUSH: begin
          // Both product stages empty means the last sample is already summed.
          if (!w_v1 && !r_v2) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign samp_ready_o = r_ready;
  assign comp_done_o  = r_done;

  ame_coef_gen #(
    .GRAD_BITS (GRAD_BITS),
    .POS_BITS  (POS_BITS)
  ) u_coef_gen (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_vld   (w_take),
    .i_mode  (r_mode),
    .i_gx    (samp_gx_i),
    .i_gy    (samp_gy_i),
    .i_x     (samp_x_i),
    .i_y     (samp_y_i),
    .i_diff  (samp_diff_i),
    .o_vld   (w_v1),
    .o_coef  (w_coef),
    .o_diff  (w_diff)
  );

  // Only the upper triangle is computed; the lower triangle is a mirror.
  for (genvar gi = 0; gi < AME_NCOEF; gi++) begin : g_row
    for (genvar gj = gi; gj < AME_NCOEF; gj++) begin : g_a
      logic signed [PW-1:0]        w_prod;
      logic [COMP_DATA_BITS-1:0]   r_prod;
      logic [COMP_DATA_BITS-1:0]   r_acc;

      assign w_prod = PW'(w_coef[gi]) * PW'(w_coef[gj]);

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_prod <= '0;
          r_acc  <= '0;
        end else begin
          if (w_v1) r_prod <= COMP_DATA_BITS'(w_prod);
          if (w_clr)     r_acc <= '0;
          else if (r_v2) r_acc <= r_acc + r_prod;
        end
      end

      assign comp_data_o[gi][gj] = r_acc;
      if (gi != gj) begin : g_mirror
        assign comp_data_o[gj][gi] = r_acc;
      end
    end

    begin : g_b
      logic signed [PW-1:0]        w_prod;
      logic [COMP_DATA_BITS-1:0]   r_prod;
      logic [COMP_DATA_BITS-1:0]   r_acc;

      assign w_prod = PW'(w_coef[gi]) * PW'(w_diff);

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_prod <= '0;
          r_acc  <= '0;
        end else begin
          if (w_v1) r_prod <= COMP_DATA_BITS'(w_prod);
          if (w_clr)     r_acc <= '0;
          else if (r_v2) r_acc <= r_acc + r_prod;
        end
      end

      assign comp_data_o[gi][AME_NCOEF] = r_acc;
    end
  end

endmodule

// File: tb/tb_ame_matrix_accumulate.sv
// Directed bench for ame_matrix_accumulate: a plain-arithmetic model of A/B is
// checked on every done pulse, plus hand-computed literals for the key vectors.
module tb_ame_matrix_accumulate;
  import ame_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               comp_init_i;
  logic               affine_param6_i;
  logic               samp_valid_i;
  logic               samp_ready_o;
  logic               samp_last_i;
  logic signed [15:0] samp_gx_i;
  logic signed [15:0] samp_gy_i;
  logic        [6:0]  samp_x_i;
  logic        [6:0]  samp_y_i;
  logic signed [15:0] samp_diff_i;
  logic               comp_done_o;
  ame_matrix_t        comp_data_o;

  always #5 clk_i = ~clk_i;

  ame_matrix_accumulate dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .comp_init_i     (comp_init_i),
    .affine_param6_i (affine_param6_i),
    .samp_valid_i    (samp_valid_i),
    .samp_ready_o    (samp_ready_o),
    .samp_last_i     (samp_last_i),
    .samp_gx_i       (samp_gx_i),
    .samp_gy_i       (samp_gy_i),
    .samp_x_i        (samp_x_i),
    .samp_y_i        (samp_y_i),
    .samp_diff_i     (samp_diff_i),
    .comp_done_o     (comp_done_o),
    .comp_data_o     (comp_data_o)
  );

  typedef struct {
    int gx;
    int gy;
    int x;
    int y;
    int diff;
  } samp_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     last_acc = 0;
  int     done_cnt = 0;
  bit     pending = 1'b0;
  bit     m6 = 1'b0;
  longint exp_m [6][7];
  samp_t  rs [64];

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endfunction

  // Reference: coefficient vector straight from the affine model equations.
  function automatic void model_add(input samp_t s);
    longint gx = s.gx;
    longint gy = s.gy;
    longint x  = s.x;
    longint y  = s.y;
    longint d  = s.diff;
    longint c [6];
    if (m6) c = '{gx, x * gx, gy, x * gy, y * gx, y * gy};
    else    c = '{0, 0, gx, gy, x * gx + y * gy, y * gx - x * gy};
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) exp_m[i][j] += c[i] * c[j];
      exp_m[i][6] += c[i] * d;
    end
  endfunction

  function automatic longint dat(input int i, input int j);
    return $signed(comp_data_o[i][j]);
  endfunction

  // Compare process: every done pulse must be expected, on time, and match the model.
  always @(negedge clk_i) begin
    if (comp_done_o) begin
      done_cnt++;
      chk("done_expected", longint'(pending), 1);
      chk("done_latency", longint'(cyc - last_acc), 3);
      pending = 1'b0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 7; j++)
          chk($sformatf("matrix[%0d][%0d]", i, j), dat(i, j), exp_m[i][j]);
    end
  end

  task automatic start_block(input bit p6);
    comp_init_i     = 1'b1;
    affine_param6_i = p6;
    @(posedge clk_i); #1;
    comp_init_i = 1'b0;
    m6 = p6;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++) exp_m[i][j] = 0;
  endtask

  task automatic send(input samp_t s, input bit last, input int gap);
    int n = 0;
    samp_gx_i    = 16'(s.gx);
    samp_gy_i    = 16'(s.gy);
    samp_x_i     = 7'(s.x);
    samp_y_i     = 7'(s.y);
    samp_diff_i  = 16'(s.diff);
    samp_valid_i = 1'b1;
    samp_last_i  = last;
    while (!samp_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!samp_ready_o) chk("ready_seen", longint'(samp_ready_o), 1);
    @(posedge clk_i); #1;
    model_add(s);
    if (last) begin
      last_acc = cyc;
      pending  = 1'b1;
    end
    samp_valid_i = 1'b0;
    samp_last_i  = 1'b0;
    repeat (gap) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!comp_done_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("done_seen", longint'(comp_done_o), 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    samp_t s1;
    samp_t sw;
    int    dc;
    bit    gapped;
    bit    p6;

    rst_n_i = 1'b0; comp_init_i = 1'b0; affine_param6_i = 1'b0;
    samp_valid_i = 1'b0; samp_last_i = 1'b0;
    samp_gx_i = '0; samp_gy_i = '0; samp_x_i = '0; samp_y_i = '0; samp_diff_i = '0;
    for (int k = 0; k < 64; k++) begin
      rs[k].gx   = int'($urandom_range(0, 65535)) - 32768;
      rs[k].gy   = int'($urandom_range(0, 65535)) - 32768;
      rs[k].x    = int'($urandom_range(0, 127));
      rs[k].y    = int'($urandom_range(0, 127));
      rs[k].diff = int'($urandom_range(0, 65535)) - 32768;
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", longint'(samp_ready_o), 0);
    chk("rst_done", longint'(comp_done_o), 0);
    chk("rst_data", longint'(|comp_data_o), 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // 6-parameter single sample: c = {1,3,2,6,4,8}
    s1 = '{gx: 1, gy: 2, x: 3, y: 4, diff: 5};
    start_block(1'b1);
    send(s1, 1'b1, 0);
    wait_done();
    chk("t1_A00", dat(0, 0), 1);
    chk("t1_A01", dat(0, 1), 3);
    chk("t1_A11", dat(1, 1), 9);
    chk("t1_A35", dat(3, 5), 48);
    chk("t1_A55", dat(5, 5), 64);
    chk("t1_B0",  dat(0, 6), 5);
    chk("t1_B5",  dat(5, 6), 40);
    chk("t1_A10", dat(1, 0), 3);

    // Valid while IDLE is not accepted and the result stays put.
    sw = '{gx: 1000, gy: -7, x: 9, y: 9, diff: 77};
    samp_gx_i = 16'(sw.gx); samp_x_i = 7'(sw.x); samp_diff_i = 16'(sw.diff);
    samp_valid_i = 1'b1;
    repeat (4) begin
      @(posedge clk_i); #1;
      chk("idle_ready", longint'(samp_ready_o), 0);
    end
    samp_valid_i = 1'b0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++) chk("hold", dat(i, j), exp_m[i][j]);

    // 4-parameter single sample: c = {0,0,1,2,11,-2}
    start_block(1'b0);
    send(s1, 1'b1, 0);
    wait_done();
    chk("t2_A44", dat(4, 4), 121);
    chk("t2_A45", dat(4, 5), -22);
    chk("t2_A55", dat(5, 5), 4);
    chk("t2_B4",  dat(4, 6), 55);
    chk("t2_B5",  dat(5, 6), -10);
    for (int j = 0; j < 7; j++) begin
      chk("t2_row0", dat(0, j), 0);
      chk("t2_row1", dat(1, j), 0);
    end
    for (int i = 2; i < 6; i++) begin
      chk("t2_col0", dat(i, 0), 0);
      chk("t2_col1", dat(i, 1), 0);
    end

    // Worst-case magnitude over the largest block.
    sw = '{gx: -32768, gy: -32768, x: 127, y: 127, diff: -32768};
    start_block(1'b1);
    for (int k = 0; k < 16384; k++) send(sw, k == 16383, 0);
    dc = done_cnt;
    wait_done();
    chk("t3_A11", dat(1, 1), longint'(16129) <<< 44);
    repeat (6) @(posedge clk_i);
    #1;
    chk("t3_one_done", longint'(done_cnt - dc), 1);

    // Same random stream back-to-back and with bubbles, in both modes.
    for (int r = 0; r < 4; r++) begin
      p6     = (r < 2);
      gapped = r[0];
      start_block(p6);
      if (gapped) repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
      for (int k = 0; k < 64; k++)
        send(rs[k], k == 63, gapped ? int'($urandom_range(0, 3)) : 0);
      wait_done();
    end

    // Init pulse during ACCUM is ignored; next block restarts from zero.
    start_block(1'b1);
    for (int k = 0; k < 32; k++) send(rs[k], 1'b0, 0);
    comp_init_i = 1'b1; affine_param6_i = 1'b0;
    @(posedge clk_i); #1;
    comp_init_i = 1'b0;
    for (int k = 32; k < 64; k++) send(rs[k], k == 63, 0);
    wait_done();
    start_block(1'b1);
    send(s1, 1'b1, 0);
    wait_done();
    chk("t5_restart_A00", dat(0, 0), 1);
    chk("t5_restart_B5", dat(5, 6), 40);

    // Reset mid-block aborts without a done pulse.
    start_block(1'b0);
    for (int k = 0; k < 10; k++) send(rs[k], 1'b0, 0);
    dc = done_cnt;
    rst_n_i = 1'b0;
    pending = 1'b0;
    #2;
    chk("arst_ready", longint'(samp_ready_o), 0);
    chk("arst_done", longint'(comp_done_o), 0);
    chk("arst_data", longint'(|comp_data_o), 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    chk("arst_no_done", longint'(done_cnt - dc), 0);
    start_block(1'b1);
    for (int k = 0; k < 5; k++) send(rs[k], k == 4, 1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
